// File: rtl/matrix_frame_sequencer_pkg.sv
// matrix_pkg: shared types and constants for the LED-matrix frame sequencer.
//   state_t       - playback FSM states
//   FRAME_W       - width of one 8x8 frame, bit [8*r+c] = row r, column c
//   dwell_cycles  - converts a dwell time in ms to clock cycles
package matrix_pkg;

    localparam int FRAME_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    function automatic int dwell_cycles(input int clk_ref_hz, input int dwell_ms);
        return dwell_ms * (clk_ref_hz / 1000);
    endfunction

endpackage

// File: rtl/matrix_frame_sequencer_if.sv
// matrix_frame_sequencer_if: host write port into the frame store.
//   wr_en   - write request
//   wr_addr - frame slot to write
//   wr_dat  - frame data
//   wr_rdy  - write accepted when wr_en & wr_rdy at a rising edge
interface matrix_frame_sequencer_if
    import matrix_pkg::*;
#(
    parameter int FRAME_DEPTH = 4
);
    logic                           wr_en;
    logic [$clog2(FRAME_DEPTH)-1:0] wr_addr;
    logic [FRAME_W-1:0]             wr_dat;
    logic                           wr_rdy;

    modport master (output wr_en, output wr_addr, output wr_dat, input wr_rdy);
    modport slave  (input wr_en, input wr_addr, input wr_dat, output wr_rdy);
endinterface

// File: rtl/matrix_frame_sequencer_frame_store.sv
// frame_store: DEPTH x FRAME_W register file holding the frames to play.
//   i_clk, i_rst_n  - clock, synchronous active-low reset (clears all slots)
//   i_we/i_waddr/i_wdat - single write port
//   i_raddr/o_rdat  - asynchronous read port
module frame_store
    import matrix_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [FRAME_W-1:0]       i_wdat,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [FRAME_W-1:0]       o_rdat
);
    logic [FRAME_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];
endmodule

// File: rtl/matrix_frame_sequencer.sv
// matrix_frame_sequencer: plays stored 8x8 frames in order, each for a fixed
// dwell time, optionally looping, and presents them to the display driver.
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   wr_bus         - host write port into the frame store
//   i_play         - rising edge starts playback, low stops it
//   i_loop         - wrap to slot 0 after the last frame (sampled at expiry)
//   i_num_fr       - number of frames to play (clamped to 1..FRAME_DEPTH)
//   o_frame/o_idx  - frame on display and its slot index (registered)
//   o_load         - one-cycle pulse when o_frame takes a new value
//   o_busy         - high in LOAD and DWELL
//   o_done         - one-cycle pulse when a non-looping sequence completes
//
// state | meaning
// IDLE  | waiting for a rising edge on i_play
// LOAD  | present slot[idx] on o_frame, start dwell timer
// DWELL | timer counting down; at zero advance, wrap or finish
// FIN   | pulse o_done, return to IDLE
module matrix_frame_sequencer
    import matrix_pkg::*;
#(
    parameter int CLK_REF     = 48_000_000,
    parameter int DWELL_MS    = 250,
    parameter int FRAME_DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    matrix_frame_sequencer_if.slave        wr_bus,
    input  logic                           i_play,
    input  logic                           i_loop,
    input  logic [$clog2(FRAME_DEPTH):0]   i_num_fr,
    output logic [FRAME_W-1:0]             o_frame,
    output logic                           o_load,
    output logic [$clog2(FRAME_DEPTH)-1:0] o_idx,
    output logic                           o_busy,
    output logic                           o_done
);
    localparam int AW        = $clog2(FRAME_DEPTH);
    localparam int NW        = AW + 1;
    localparam int DWELL_CYC = dwell_cycles(CLK_REF, DWELL_MS);
    localparam int CW        = $clog2(DWELL_CYC);

    state_t             r_state, w_state_nxt;
    logic [AW-1:0]      r_idx, w_idx_nxt;
    logic [NW-1:0]      r_nfr, w_nfr_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [FRAME_W-1:0] r_frame, w_frame_nxt;
    logic [AW-1:0]      r_idx_o, w_idx_o_nxt;
    logic               r_load, w_load_nxt;
    logic               r_done, w_done_nxt;
    logic               r_play_q;
    logic [FRAME_W-1:0] w_rd_dat;
    logic               w_wr_rdy;
    logic               w_last;

    assign w_wr_rdy      = (r_state != ST_LOAD);
    assign wr_bus.wr_rdy = w_wr_rdy;

    frame_store #(.DEPTH(FRAME_DEPTH)) u_store (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (wr_bus.wr_en & w_wr_rdy),
        .i_waddr (wr_bus.wr_addr),
        .i_wdat  (wr_bus.wr_dat),
        .i_raddr (r_idx),
        .o_rdat  (w_rd_dat)
    );

    assign w_last = (({1'b0, r_idx} + NW'(1)) == r_nfr);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_nfr_nxt   = r_nfr;
        w_cnt_nxt   = r_cnt;
        w_frame_nxt = r_frame;
        w_idx_o_nxt = r_idx_o;
        w_load_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_play && !r_play_q) begin
                    if (i_num_fr == '0) begin
                        w_nfr_nxt = NW'(1);
                    end else if (i_num_fr > NW'(FRAME_DEPTH)) begin
                        w_nfr_nxt = NW'(FRAME_DEPTH);
                    end else begin
                        w_nfr_nxt = i_num_fr;
                    end
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!i_play) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_frame_nxt = w_rd_dat;
                    w_idx_o_nxt = r_idx;
                    w_load_nxt  = 1'b1;
                    // LOAD itself is one cycle of the dwell, hence -2
                    w_cnt_nxt   = CW'(DWELL_CYC - 2);
                    w_state_nxt = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (!i_play) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (!w_last) begin
                    w_idx_nxt   = r_idx + AW'(1);
                    w_state_nxt = ST_LOAD;
                end else if (i_loop) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_nfr    <= '0;
            r_cnt    <= '0;
            r_frame  <= '0;
            r_idx_o  <= '0;
            r_load   <= 1'b0;
            r_done   <= 1'b0;
            r_play_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_nfr    <= w_nfr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_frame  <= w_frame_nxt;
            r_idx_o  <= w_idx_o_nxt;
            r_load   <= w_load_nxt;
            r_done   <= w_done_nxt;
            r_play_q <= i_play;
        end
    end

    assign o_frame = r_frame;
    assign o_load  = r_load;
    assign o_idx   = r_idx_o;
    assign o_done  = r_done;
    assign o_busy  = (r_state == ST_LOAD) || (r_state == ST_DWELL);
endmodule
